// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Bus/register widths, access size encodings and FSM state codes.
package mem_lsu_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;

    // Access size encodings; 2'b11 is handled as a word access.
    localparam logic [1:0] LS_SIZE_B = 2'b00;
    localparam logic [1:0] LS_SIZE_H = 2'b01;
    localparam logic [1:0] LS_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_WAIT = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational data-path helpers for mem_lsu.
// Ports:
//   size, is_unsigned, addr_lo : access size, zero-extend flag, addr[1:0]
//   wdata                      : right-aligned store data
//   rword                      : captured read word
//   be                         : byte enables for the bus
//   wdata_lanes                : store data replicated across lanes
//   load_data                  : shifted and extended load result
//   misalign                   : access not naturally aligned
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]             size,
    input  logic                   is_unsigned,
    input  logic [1:0]             addr_lo,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [DATA_WIDTH-1:0]  rword,
    output logic [3:0]             be,
    output logic [DATA_WIDTH-1:0]  wdata_lanes,
    output logic [RDATA_WIDTH-1:0] load_data,
    output logic                   misalign
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        // Bring the addressed byte/half down to bit 0.
        shifted     = rword >> {addr_lo, 3'b000};
        be          = 4'b1111;
        wdata_lanes = wdata;
        load_data   = shifted;
        misalign    = 1'b0;
        case (size)
            LS_SIZE_B: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                load_data   = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
                misalign    = 1'b0;
            end
            LS_SIZE_H: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                load_data   = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
                misalign    = addr_lo[0];
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
                load_data   = shifted;
                misalign    = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Non-memory instructions pass straight through;
// aligned loads/stores run a req/ack bus transaction (IDLE -> WAIT -> DONE)
// while holding the upstream pipeline, bounded by TIMEOUT wait cycles.
// Handshake: dbus_req_o is held high for every WAIT cycle; the access
// completes on the first cycle where dbus_ack_i is high, with dbus_rdata_i
// valid in that same cycle. ack is ignored outside WAIT.
// Ports:
//   clk_i, rst_i                       : clock, async active-high reset
//   ls_en_i, ls_we_i, ls_size_i,
//   ls_unsigned_i, addr_i, wdata_i     : memory op description from exe_mem
//   reg_w*_i / reg_w*_o                : writeback fields in / to mem_wb
//   stall_o, misalign_o, err_o         : pipeline hold, alignment fault, timeout pulse
//   dbus_*                             : data bus request side
//   state_o                            : current FSM state (debug)
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ls_en_i,
    input  logic                   ls_we_i,
    input  logic [1:0]             ls_size_i,
    input  logic                   ls_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0]  wdata_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [RDATA_WIDTH-1:0] reg_wdata_o,
    output logic                   stall_o,
    output logic                   misalign_o,
    output logic                   err_o,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
    output logic [3:0]             dbus_be_o,
    output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
    input  logic                   dbus_ack_i,
    input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
    output logic [1:0]             state_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [3:0]             be;
    logic [DATA_WIDTH-1:0]  wdata_lanes;
    logic [RDATA_WIDTH-1:0] load_data;
    logic                   misalign;
    logic                   timeout_hit;

    mem_lsu_align u_align (
        .size        (ls_size_i),
        .is_unsigned (ls_unsigned_i),
        .addr_lo     (addr_i[1:0]),
        .wdata       (wdata_i),
        .rword       (rdata_q),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign state_o     = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= LSU_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (ls_en_i && !misalign) state <= LSU_WAIT;
                end
                LSU_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // ack beats timeout when both land in the last cycle.
                    if (dbus_ack_i) begin
                        rdata_q <= dbus_rdata_i;
                        state   <= LSU_DONE;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                    state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

    // Outputs decode from state so that reset forces them low with no edge.
    always_comb begin
        reg_waddr_o  = '0;
        reg_we_o     = 1'b0;
        reg_wdata_o  = '0;
        stall_o      = 1'b0;
        misalign_o   = 1'b0;
        err_o        = 1'b0;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = '0;
        dbus_be_o    = '0;
        dbus_wdata_o = '0;
        if (!rst_i) begin
            case (state)
                LSU_IDLE: begin
                    reg_waddr_o = reg_waddr_i;
                    reg_wdata_o = reg_wdata_i;
                    reg_we_o    = reg_we_i & ~ls_en_i;
                    stall_o     = ls_en_i & ~misalign;
                    misalign_o  = ls_en_i & misalign;
                end
                LSU_WAIT: begin
                    reg_waddr_o  = reg_waddr_i;
                    reg_wdata_o  = reg_wdata_i;
                    stall_o      = 1'b1;
                    dbus_req_o   = 1'b1;
                    dbus_we_o    = ls_we_i;
                    dbus_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                    dbus_be_o    = be;
                    dbus_wdata_o = wdata_lanes;
                end
                LSU_DONE: begin
                    reg_waddr_o = reg_waddr_i;
                    reg_wdata_o = load_data;
                    reg_we_o    = reg_we_i & ~ls_we_i & ~err_q;
                    err_o       = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ls_en_i = 0, ls_we_i = 0, ls_unsigned_i = 0;
    logic [1:0]  ls_size_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0;
    logic [4:0]  reg_waddr_i = 0;
    logic        reg_we_i = 0;
    logic [31:0] reg_wdata_i = 0;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stall_o, misalign_o, err_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i = 0;
    logic [31:0] dbus_rdata_i = 0;
    logic [1:0]  state_o;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .ls_en_i(ls_en_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
        .ls_unsigned_i(ls_unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .stall_o(stall_o), .misalign_o(misalign_o), .err_o(err_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
        .state_o(state_o)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] waddr);
        ls_en_i       = 1'b1;
        ls_we_i       = we;
        ls_size_i     = size;
        ls_unsigned_i = uns;
        addr_i        = addr;
        wdata_i       = wdata;
        reg_waddr_i   = waddr;
        reg_we_i      = 1'b1;
        reg_wdata_i   = 32'h0;
    endtask

    // Runs an aligned access already presented in IDLE. ack_at = WAIT cycle
    // (1-based) in which ack is raised, 0 = never. Checks bus fields on the
    // first WAIT cycle and writeback/error in DONE.
    task automatic run_access(input string tag, input int ack_at, input logic [31:0] rdata,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic exp_bwe, input logic [31:0] exp_bwdata,
                              input int exp_waits, input logic exp_we,
                              input logic [31:0] exp_wdata, input logic exp_err);
        int waits;
        check({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
        check({tag, "_idle_we"}, 32'(reg_we_o), 32'd0);
        waits = 0;
        step();
        check({tag, "_addr"}, dbus_addr_o, exp_addr);
        check({tag, "_be"}, 32'(dbus_be_o), 32'(exp_be));
        check({tag, "_bwe"}, 32'(dbus_we_o), 32'(exp_bwe));
        check({tag, "_bwdata"}, dbus_wdata_o, exp_bwdata);
        while (dbus_req_o && waits < 40) begin
            waits++;
            if (stall_o !== 1'b1) check({tag, "_wait_stall"}, 32'(stall_o), 32'd1);
            if (waits == ack_at) begin
                dbus_ack_i   = 1'b1;
                dbus_rdata_i = rdata;
            end
            step();
            dbus_ack_i = 1'b0;
        end
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check({tag, "_done_state"}, 32'(state_o), 32'(LSU_DONE));
        check({tag, "_done_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_done_we"}, 32'(reg_we_o), 32'(exp_we));
        if (exp_we) begin
            exp_q.push_back(exp_wdata);
            check({tag, "_done_wdata"}, reg_wdata_o, exp_q.pop_front());
        end
        check({tag, "_done_err"}, 32'(err_o), 32'(exp_err));
        ls_en_i = 1'b0;
        step();
        check({tag, "_back_idle"}, 32'(state_o), 32'(LSU_IDLE));
        check({tag, "_err_clear"}, 32'(err_o), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reg_wdata_i = 32'h1234;
        reg_we_i    = 1'b1;
        reg_waddr_i = 5'd3;
        #1;
        check("rst_wdata", reg_wdata_o, 32'h0);
        check("rst_we", 32'(reg_we_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(LSU_IDLE));
        step();
        step();
        rst = 1'b0;
        #1;

        // ALU pass-through
        check("alu_wdata", reg_wdata_o, 32'h1234);
        check("alu_we", 32'(reg_we_o), 32'd1);
        check("alu_waddr", 32'(reg_waddr_o), 32'd3);
        check("alu_stall", 32'(stall_o), 32'd0);
        check("alu_req", 32'(dbus_req_o), 32'd0);

        // LB / LBU at 0x103, byte 0x80
        set_op(1'b0, LS_SIZE_B, 1'b0, 32'h103, 32'h0, 5'd7);
        #1;
        run_access("lb", 1, 32'h80FF_0000, 32'h100, 4'b1000, 1'b0, 32'h0,
                   1, 1'b1, 32'hFFFF_FF80, 1'b0);
        set_op(1'b0, LS_SIZE_B, 1'b1, 32'h103, 32'h0, 5'd7);
        #1;
        run_access("lbu", 1, 32'h80FF_0000, 32'h100, 4'b1000, 1'b0, 32'h0,
                   1, 1'b1, 32'h0000_0080, 1'b0);

        // LH / LHU
        set_op(1'b0, LS_SIZE_H, 1'b0, 32'h102, 32'h0, 5'd8);
        #1;
        run_access("lh", 2, 32'h8001_1234, 32'h100, 4'b1100, 1'b0, 32'h0,
                   2, 1'b1, 32'hFFFF_8001, 1'b0);
        set_op(1'b0, LS_SIZE_H, 1'b1, 32'h100, 32'h0, 5'd8);
        #1;
        run_access("lhu", 1, 32'h8001_9234, 32'h100, 4'b0011, 1'b0, 32'h0,
                   1, 1'b1, 32'h0000_9234, 1'b0);

        // SH at 0x102, SB at 0x101, SW at 0x104
        set_op(1'b1, LS_SIZE_H, 1'b0, 32'h102, 32'h0000_ABCD, 5'd9);
        #1;
        run_access("sh", 1, 32'h0, 32'h100, 4'b1100, 1'b1, 32'hABCD_ABCD,
                   1, 1'b0, 32'h0, 1'b0);
        set_op(1'b1, LS_SIZE_B, 1'b0, 32'h101, 32'h1234_565A, 5'd9);
        #1;
        run_access("sb", 3, 32'h0, 32'h100, 4'b0010, 1'b1, 32'h5A5A_5A5A,
                   3, 1'b0, 32'h0, 1'b0);
        set_op(1'b1, 2'b11, 1'b0, 32'h104, 32'hCAFE_F00D, 5'd9);
        #1;
        run_access("sw", 1, 32'h0, 32'h104, 4'b1111, 1'b1, 32'hCAFE_F00D,
                   1, 1'b0, 32'h0, 1'b0);

        // Misaligned accesses: no bus cycle, no stall
        set_op(1'b0, LS_SIZE_W, 1'b0, 32'h101, 32'h0, 5'd4);
        #1;
        check("mis_lw_flag", 32'(misalign_o), 32'd1);
        check("mis_lw_stall", 32'(stall_o), 32'd0);
        check("mis_lw_we", 32'(reg_we_o), 32'd0);
        step();
        check("mis_lw_req", 32'(dbus_req_o), 32'd0);
        check("mis_lw_state", 32'(state_o), 32'(LSU_IDLE));
        set_op(1'b1, LS_SIZE_H, 1'b0, 32'h103, 32'h0, 5'd4);
        #1;
        check("mis_sh_flag", 32'(misalign_o), 32'd1);
        step();
        check("mis_sh_req", 32'(dbus_req_o), 32'd0);
        set_op(1'b0, LS_SIZE_B, 1'b0, 32'h103, 32'h0, 5'd4);
        #1;
        check("byte_never_mis", 32'(misalign_o), 32'd0);
        ls_en_i = 1'b0;
        #1;

        // Timeout with TIMEOUT=4: no ack, then ack in the last WAIT cycle
        set_op(1'b0, LS_SIZE_W, 1'b0, 32'h200, 32'h0, 5'd10);
        #1;
        run_access("tmo", 0, 32'h0, 32'h200, 4'b1111, 1'b0, 32'h0,
                   4, 1'b0, 32'h0, 1'b1);
        set_op(1'b0, LS_SIZE_W, 1'b0, 32'h200, 32'h0, 5'd10);
        #1;
        run_access("ack_last", 4, 32'hDEAD_BEEF, 32'h200, 4'b1111, 1'b0, 32'h0,
                   4, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Reset in the middle of WAIT
        set_op(1'b0, LS_SIZE_W, 1'b0, 32'h300, 32'h0, 5'd11);
        step();
        check("mid_req", 32'(dbus_req_o), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(dbus_req_o), 32'd0);
        check("mid_rst_stall", 32'(stall_o), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'(LSU_IDLE));
        ls_en_i     = 1'b0;
        reg_wdata_i = 32'h5555_0001;
        reg_waddr_i = 5'd12;
        reg_we_i    = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("post_rst_wdata", reg_wdata_o, 32'h5555_0001);
        check("post_rst_we", 32'(reg_we_o), 32'd1);
        check("post_rst_stall", 32'(stall_o), 32'd0);
        step();
        check("post_rst_idle", 32'(state_o), 32'(LSU_IDLE));

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
